// File: rtl/rv_iopmp_pkg.sv
// rv_iopmp_pkg: shared types for the IOPMP blocks.
//   access_t      - transaction access type (value 0 is the reset/idle encoding)
//   err_state_e   - error-capture FSM states (ERR_IDLE, ERR_LOGGED)
//   ERR_TYPE_*    - 3-bit error-type encodings reported by the decision logic
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } access_t;

    typedef enum logic [0:0] {
        ERR_IDLE   = 1'b0,
        ERR_LOGGED = 1'b1
    } err_state_e;

    localparam logic [2:0] ERR_TYPE_NONE      = 3'd0;
    localparam logic [2:0] ERR_TYPE_ILL_READ  = 3'd1;
    localparam logic [2:0] ERR_TYPE_ILL_WRITE = 3'd2;
    localparam logic [2:0] ERR_TYPE_ILL_EXEC  = 3'd3;
    localparam logic [2:0] ERR_TYPE_PARTIAL   = 3'd4;
    localparam logic [2:0] ERR_TYPE_NO_HIT    = 3'd5;
    localparam logic [2:0] ERR_TYPE_UNK_RRID  = 3'd6;

endpackage

// File: rtl/rv_iopmp_err_capture.sv
// rv_iopmp_err_capture: captures the first IOPMP violation reported by the decision logic
// and holds it until software clears it. Sits downstream of rv_iopmp_dl_wrapper and feeds
// the register file.
//
// Optional feature: define RV_IOPMP_ERR_CNT_EN to count (saturating) errors dropped while a
// record is held; otherwise err_cnt_o is tied to 0 and no counter flops exist.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   dec_valid_i                decision outputs valid this cycle
//   err_transaction_i          decision flagged an error (qualified by dec_valid_i)
//   err_type_i, err_entry_index_i, sid_i, addr_i, access_type_i   error record inputs
//   ie_i                       interrupt enable
//   clear_i                    one-cycle pulse releasing the record
//   err_valid_o                record held
//   err_type_o, err_eid_o, err_sid_o, err_addr_o, err_ttype_o      captured record
//   err_cnt_o                  dropped-error count
//   irq_o                      registered level interrupt
module rv_iopmp_err_capture
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dec_valid_i,
    input  logic                  err_transaction_i,
    input  logic [2:0]            err_type_i,
    input  logic [15:0]           err_entry_index_i,
    input  logic [SID_WIDTH-1:0]  sid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  access_t               access_type_i,
    input  logic                  ie_i,
    input  logic                  clear_i,
    output logic                  err_valid_o,
    output logic [2:0]            err_type_o,
    output logic [15:0]           err_eid_o,
    output logic [SID_WIDTH-1:0]  err_sid_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output access_t               err_ttype_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  irq_o
);

    err_state_e state_q;
    logic       err_event;
    logic       capture;
    logic       next_logged;

    logic [2:0]            type_q;
    logic [15:0]           eid_q;
    logic [SID_WIDTH-1:0]  sid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    access_t               ttype_q;
    logic                  irq_q;

    assign err_event = dec_valid_i & err_transaction_i;

    // Capture in IDLE, or in LOGGED when a clear coincides with a new error (the new error
    // replaces the released record rather than being lost).
    always_comb begin
        capture     = 1'b0;
        next_logged = 1'b0;
        unique case (state_q)
            ERR_IDLE: begin
                capture     = err_event;
                next_logged = err_event;
            end
            ERR_LOGGED: begin
                capture     = clear_i & err_event;
                next_logged = ~clear_i | err_event;
            end
            default: begin
                capture     = 1'b0;
                next_logged = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ERR_IDLE;
            type_q  <= '0;
            eid_q   <= '0;
            sid_q   <= '0;
            addr_q  <= '0;
            ttype_q <= ACC_NONE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= next_logged ? ERR_LOGGED : ERR_IDLE;
            if (capture) begin
                type_q  <= err_type_i;
                eid_q   <= err_entry_index_i;
                sid_q   <= sid_i;
                addr_q  <= addr_i;
                ttype_q <= access_type_i;
            end
            irq_q <= next_logged & ie_i;
        end
    end

`ifdef RV_IOPMP_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == ERR_LOGGED) begin
            if (clear_i) begin
                cnt_q <= '0;
            end else if (err_event && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign err_cnt_o = cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign err_valid_o = (state_q == ERR_LOGGED);
    assign err_type_o  = type_q;
    assign err_eid_o   = eid_q;
    assign err_sid_o   = sid_q;
    assign err_addr_o  = addr_q;
    assign err_ttype_o = ttype_q;
    assign irq_o       = irq_q;

endmodule
